// File: rtl/hs_rx_pkg.sv
// rtl/hs_rx_pkg.sv - shared state encoding and default timing constants for the HS receive sequencer
package hs_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_WAIT_SOT = 3'd2,
    ST_RECEIVE  = 3'd3,
    ST_EOT      = 3'd4,
    ST_HOLD     = 3'd5
  } hs_seq_state_t;

  localparam int unsigned HS_SETTLE_DEF      = 8;
  localparam int unsigned HS_SOT_TIMEOUT_DEF = 64;

  // Saturation ceiling of the 8-bit statistics counters.
  localparam logic [7:0] HS_CNT_MAX = 8'd255;

endpackage

// File: rtl/hs_seq_stats.sv
// rtl/hs_seq_stats.sv - per-lane burst and trailer-break statistics counters
module hs_seq_stats
  import hs_rx_pkg::*;
(
  input  logic       clk_comparator,
  input  logic       RST,
  input  logic       err_clr,
  input  logic       break_hit,
  input  logic       eot_hit,
  output logic [7:0] break_cnt,
  output logic [7:0] burst_cnt
);

  // Break count saturates so a noisy lane cannot alias to a small value; burst count wraps.
  always_ff @(posedge clk_comparator or negedge RST) begin
    if (!RST) begin
      break_cnt <= 8'd0;
      burst_cnt <= 8'd0;
    end else if (err_clr) begin
      break_cnt <= 8'd0;
      burst_cnt <= 8'd0;
    end else begin
      if (break_hit && (break_cnt != HS_CNT_MAX)) begin
        break_cnt <= break_cnt + 8'd1;
      end
      if (eot_hit) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/hs_rx_sequencer.sv
// rtl/hs_rx_sequencer.sv - HS receive lane control FSM; optional statistics under HS_SEQ_STATS_EN
module hs_rx_sequencer
  import hs_rx_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = HS_SETTLE_DEF,
  parameter int unsigned SOT_TIMEOUT   = HS_SOT_TIMEOUT_DEF
) (
  input  logic       clk_comparator,
  input  logic       RST,
  input  logic       hs_rx_en,
  input  logic       sot_detected,
  input  logic       trailer_done,
  input  logic       break_trailer_c,
  input  logic       fifo_full,
  input  logic       err_clr,
  output logic       comparator_enable,
  output logic       rx_active,
  output logic       eot_pulse,
  output logic       err_sot,
  output logic       err_ovf,
  output logic [2:0] seq_state
`ifdef HS_SEQ_STATS_EN
  ,
  output logic [7:0] break_cnt,
  output logic [7:0] burst_cnt
`endif
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SOT_LAST    = 8'(SOT_TIMEOUT - 1);

  hs_seq_state_t state;
  hs_seq_state_t state_nxt;
  logic [7:0]    cnt;
  logic [7:0]    cnt_nxt;
  logic          set_sot;
  logic          set_ovf;

  assign seq_state = state;

  // Next-state and counter decode; dropping hs_rx_en overrides every other transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = 8'd0;
    set_sot   = 1'b0;
    set_ovf   = 1'b0;
    if (!hs_rx_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = ST_WAIT_SOT;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        ST_WAIT_SOT: begin
          if (sot_detected) begin
            state_nxt = ST_RECEIVE;
          end else if (cnt == SOT_LAST) begin
            state_nxt = ST_HOLD;
            set_sot   = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        ST_RECEIVE: begin
          if (fifo_full) begin
            state_nxt = ST_HOLD;
            set_ovf   = 1'b1;
          end else if (trailer_done) begin
            state_nxt = ST_EOT;
          end
        end
        ST_EOT: begin
          state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          state_nxt = ST_HOLD;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and outputs registered together so outputs track the state edge exactly.
  always_ff @(posedge clk_comparator or negedge RST) begin
    if (!RST) begin
      state             <= ST_IDLE;
      cnt               <= 8'd0;
      comparator_enable <= 1'b0;
      rx_active         <= 1'b0;
      eot_pulse         <= 1'b0;
      err_sot           <= 1'b0;
      err_ovf           <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      comparator_enable <= (state_nxt == ST_RECEIVE);
      rx_active         <= (state_nxt == ST_RECEIVE);
      eot_pulse         <= (state_nxt == ST_EOT);
      if (set_sot) begin
        err_sot <= 1'b1;
      end else if (err_clr) begin
        err_sot <= 1'b0;
      end
      if (set_ovf) begin
        err_ovf <= 1'b1;
      end else if (err_clr) begin
        err_ovf <= 1'b0;
      end
    end
  end

`ifdef HS_SEQ_STATS_EN
  hs_seq_stats u_stats (
    .clk_comparator (clk_comparator),
    .RST            (RST),
    .err_clr        (err_clr),
    .break_hit      (break_trailer_c && (state == ST_RECEIVE)),
    .eot_hit        (eot_pulse),
    .break_cnt      (break_cnt),
    .burst_cnt      (burst_cnt)
  );
`else
  // break_trailer_c only feeds the statistics block; without it the pulse has no consumer.
  logic unused_break;
  assign unused_break = break_trailer_c;
`endif

endmodule

// File: tb/tb_hs_rx_sequencer.sv
// tb/tb_hs_rx_sequencer.sv - directed self-checking bench for hs_rx_sequencer
module tb_hs_rx_sequencer;

  logic       clk_comparator;
  logic       RST;
  logic       hs_rx_en;
  logic       sot_detected;
  logic       trailer_done;
  logic       break_trailer_c;
  logic       fifo_full;
  logic       err_clr;
  logic       comparator_enable;
  logic       rx_active;
  logic       eot_pulse;
  logic       err_sot;
  logic       err_ovf;
  logic [2:0] seq_state;
`ifdef HS_SEQ_STATS_EN
  logic [7:0] break_cnt;
  logic [7:0] burst_cnt;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  hs_rx_sequencer dut (
    .clk_comparator    (clk_comparator),
    .RST               (RST),
    .hs_rx_en          (hs_rx_en),
    .sot_detected      (sot_detected),
    .trailer_done      (trailer_done),
    .break_trailer_c   (break_trailer_c),
    .fifo_full         (fifo_full),
    .err_clr           (err_clr),
    .comparator_enable (comparator_enable),
    .rx_active         (rx_active),
    .eot_pulse         (eot_pulse),
    .err_sot           (err_sot),
    .err_ovf           (err_ovf),
    .seq_state         (seq_state)
`ifdef HS_SEQ_STATS_EN
    ,
    .break_cnt         (break_cnt),
    .burst_cnt         (burst_cnt)
`endif
  );

  initial begin
    clk_comparator = 1'b0;
    forever #5 clk_comparator = ~clk_comparator;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_comparator);
      #1;
    end
  endtask

  // Brings the lane from IDLE into RECEIVE: 1 edge to SETTLE, 8 to WAIT_SOT, 1 for SOT.
  task automatic go_receive();
    hs_rx_en = 1'b1;
    tick(9);
    sot_detected = 1'b1;
    tick(1);
    sot_detected = 1'b0;
    chk_cnt++;
    if (seq_state !== 3'd3) $display("FAIL go_receive state got=%0d exp=3", seq_state);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(2);
    chk_cnt++;
    if ({comparator_enable, rx_active, eot_pulse, err_sot, err_ovf} !== 5'b0)
      $display("FAIL reset_outputs got=%b exp=00000",
               {comparator_enable, rx_active, eot_pulse, err_sot, err_ovf});
    else pass_cnt++;
    chk_cnt++;
    if (seq_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", seq_state);
    else pass_cnt++;
    #2 RST = 1'b1;
    tick(2);
    chk_cnt++;
    if (seq_state !== 3'd0) $display("FAIL idle_hold_en0 got=%0d exp=0", seq_state);
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    logic [2:0] exp_st;
    hs_rx_en = 1'b1;
    for (int cyc = 1; cyc <= 44; cyc++) begin
      sot_detected = (cyc - 1 == 12);
      trailer_done = (cyc - 1 == 40);
      tick(1);
      if (cyc < 9)        exp_st = 3'd1;
      else if (cyc < 13)  exp_st = 3'd2;
      else if (cyc <= 40) exp_st = 3'd3;
      else if (cyc == 41) exp_st = 3'd4;
      else                exp_st = 3'd5;
      chk_cnt++;
      if (seq_state !== exp_st)
        $display("FAIL nominal_state cyc=%0d got=%0d exp=%0d", cyc, seq_state, exp_st);
      else pass_cnt++;
      chk_cnt++;
      if (rx_active !== (cyc >= 13 && cyc <= 40) || comparator_enable !== (cyc >= 13 && cyc <= 40))
        $display("FAIL nominal_rx cyc=%0d got=%b%b exp=%b", cyc, rx_active, comparator_enable,
                 (cyc >= 13 && cyc <= 40));
      else pass_cnt++;
      chk_cnt++;
      if (eot_pulse !== (cyc == 41))
        $display("FAIL nominal_eot cyc=%0d got=%b exp=%b", cyc, eot_pulse, (cyc == 41));
      else pass_cnt++;
    end
    sot_detected = 1'b0;
    trailer_done = 1'b0;
    hs_rx_en = 1'b0;
    tick(1);
    chk_cnt++;
    if (seq_state !== 3'd0 || err_sot !== 1'b0 || err_ovf !== 1'b0)
      $display("FAIL nominal_exit got=%0d/%b%b exp=0/00", seq_state, err_sot, err_ovf);
    else pass_cnt++;
  endtask

  task automatic test_sot_timeout();
    hs_rx_en = 1'b1;
    tick(9);
    chk_cnt++;
    if (seq_state !== 3'd2) $display("FAIL to_wait got=%0d exp=2", seq_state);
    else pass_cnt++;
    tick(63);
    chk_cnt++;
    if (seq_state !== 3'd2 || err_sot !== 1'b0)
      $display("FAIL to_last_wait got=%0d/%b exp=2/0", seq_state, err_sot);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (seq_state !== 3'd5 || err_sot !== 1'b1 || comparator_enable !== 1'b0)
      $display("FAIL to_hold got=%0d/%b/%b exp=5/1/0", seq_state, err_sot, comparator_enable);
    else pass_cnt++;
    tick(3);
    chk_cnt++;
    if (err_sot !== 1'b1 || seq_state !== 3'd5)
      $display("FAIL to_sticky got=%b/%0d exp=1/5", err_sot, seq_state);
    else pass_cnt++;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk_cnt++;
    if (err_sot !== 1'b0) $display("FAIL to_clear got=%b exp=0", err_sot);
    else pass_cnt++;
    hs_rx_en = 1'b0;
    tick(1);
  endtask

  task automatic test_sot_on_timeout();
    hs_rx_en = 1'b1;
    tick(72);
    sot_detected = 1'b1;
    tick(1);
    sot_detected = 1'b0;
    chk_cnt++;
    if (seq_state !== 3'd3 || err_sot !== 1'b0 || rx_active !== 1'b1)
      $display("FAIL sot_wins got=%0d/%b/%b exp=3/0/1", seq_state, err_sot, rx_active);
    else pass_cnt++;
  endtask

  task automatic test_overflow_tie();
    break_trailer_c = 1'b1;
    tick(2);
    break_trailer_c = 1'b0;
    chk_cnt++;
    if (seq_state !== 3'd3) $display("FAIL break_info got=%0d exp=3", seq_state);
    else pass_cnt++;
    fifo_full = 1'b1;
    trailer_done = 1'b1;
    tick(1);
    fifo_full = 1'b0;
    trailer_done = 1'b0;
    chk_cnt++;
    if (seq_state !== 3'd5 || err_ovf !== 1'b1 || eot_pulse !== 1'b0 || rx_active !== 1'b0)
      $display("FAIL ovf_tie got=%0d/%b/%b/%b exp=5/1/0/0", seq_state, err_ovf, eot_pulse, rx_active);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (eot_pulse !== 1'b0 || seq_state !== 3'd5)
      $display("FAIL ovf_no_eot got=%b/%0d exp=0/5", eot_pulse, seq_state);
    else pass_cnt++;
    hs_rx_en = 1'b0;
    tick(1);
    go_receive();
    fifo_full = 1'b1;
    err_clr = 1'b1;
    tick(1);
    fifo_full = 1'b0;
    err_clr = 1'b0;
    chk_cnt++;
    if (err_ovf !== 1'b1) $display("FAIL ovf_set_wins got=%b exp=1", err_ovf);
    else pass_cnt++;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk_cnt++;
    if (err_ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", err_ovf);
    else pass_cnt++;
    hs_rx_en = 1'b0;
    tick(1);
  endtask

  task automatic test_abort();
    go_receive();
    tick(4);
    hs_rx_en = 1'b0;
    tick(1);
    chk_cnt++;
    if (seq_state !== 3'd0) $display("FAIL abort_state got=%0d exp=0", seq_state);
    else pass_cnt++;
    chk_cnt++;
    if ({comparator_enable, rx_active, eot_pulse, err_sot, err_ovf} !== 5'b0)
      $display("FAIL abort_outputs got=%b exp=00000",
               {comparator_enable, rx_active, eot_pulse, err_sot, err_ovf});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    go_receive();
    #2 RST = 1'b0;
    #1;
    chk_cnt++;
    if (rx_active !== 1'b0 || comparator_enable !== 1'b0 || seq_state !== 3'd0)
      $display("FAIL areset got=%b/%b/%0d exp=0/0/0", rx_active, comparator_enable, seq_state);
    else pass_cnt++;
    #2 RST = 1'b1;
    tick(1);
    chk_cnt++;
    if (seq_state !== 3'd1) $display("FAIL areset_restart got=%0d exp=1", seq_state);
    else pass_cnt++;
    tick(8);
    sot_detected = 1'b1;
    tick(1);
    sot_detected = 1'b0;
    chk_cnt++;
    if (rx_active !== 1'b1 || seq_state !== 3'd3)
      $display("FAIL areset_receive got=%b/%0d exp=1/3", rx_active, seq_state);
    else pass_cnt++;
    hs_rx_en = 1'b0;
    tick(1);
  endtask

`ifdef HS_SEQ_STATS_EN
  task automatic test_stats();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    go_receive();
    for (int i = 0; i < 300; i++) begin
      break_trailer_c = 1'b1;
      tick(1);
      break_trailer_c = 1'b0;
      tick(1);
    end
    chk_cnt++;
    if (break_cnt !== 8'd255) $display("FAIL break_sat got=%0d exp=255", break_cnt);
    else pass_cnt++;
    hs_rx_en = 1'b0;
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    for (int b = 0; b < 3; b++) begin
      go_receive();
      trailer_done = 1'b1;
      tick(1);
      trailer_done = 1'b0;
      tick(2);
      hs_rx_en = 1'b0;
      tick(1);
    end
    chk_cnt++;
    if (burst_cnt !== 8'd3) $display("FAIL burst_cnt got=%0d exp=3", burst_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    RST             = 1'b0;
    hs_rx_en        = 1'b0;
    sot_detected    = 1'b0;
    trailer_done    = 1'b0;
    break_trailer_c = 1'b0;
    fifo_full       = 1'b0;
    err_clr         = 1'b0;
    test_reset();
    test_nominal();
    test_sot_timeout();
    test_sot_on_timeout();
    test_overflow_tie();
    test_abort();
    test_async_reset();
`ifdef HS_SEQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hs_rx_sequencer.md
# hs_rx_sequencer

Control FSM for one high-speed receive lane, built around the trailer comparator in `HS_FIFO`. It waits out the HS settle interval and then waits for start-of-transmission. Once SOT arrives it enables the trailer comparator and gates FIFO writes while payload is received. It closes the burst on `trailer_done`, and flags SOT timeout and FIFO overflow as sticky errors for the lane controller.

## Interface
Parameters:
- SETTLE_CYCLES, 8: clk_comparator cycles spent in SETTLE before SOT search; legal range 1..255.
- SOT_TIMEOUT, 64: maximum WAIT_SOT cycles before err_sot is raised; legal range 1..255.

Ports:
- clk_comparator  in  1  block clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- hs_rx_en  in  1  lane is in HS receive mode; level signal.
- sot_detected  in  1  one-cycle pulse from the sync-byte detector.
- trailer_done  in  1  from the comparator; trailer run length reached.
- break_trailer_c  in  1  one-cycle pulse from the comparator; a candidate trailer run was broken by data.
- fifo_full  in  1  HS FIFO full flag.
- err_clr  in  1  clears the sticky error flags.
- comparator_enable  out  1  drives the comparator enable input.
- rx_active  out  1  FIFO write gate; payload is valid.
- eot_pulse  out  1  one-cycle end-of-transmission strobe.
- err_sot  out  1  sticky SOT timeout flag.
- err_ovf  out  1  sticky FIFO overflow flag.
- seq_state  out  3  current state encoding.

## Operation
States and encodings: IDLE=0, SETTLE=1, WAIT_SOT=2, RECEIVE=3, EOT=4, HOLD=5.

Transitions:
- IDLE -> SETTLE when hs_rx_en=1. The cycle counter cnt (8 bits) is cleared on entry.
- SETTLE -> WAIT_SOT when cnt==SETTLE_CYCLES-1. Otherwise cnt increments. cnt is cleared on exit.
- WAIT_SOT -> RECEIVE on sot_detected.
- WAIT_SOT -> HOLD with err_sot set when cnt==SOT_TIMEOUT-1 and no sot_detected. If sot_detected arrives on the timeout cycle, SOT wins.
- RECEIVE: comparator_enable=1 and rx_active=1.
- RECEIVE -> EOT on trailer_done.
- RECEIVE -> HOLD with err_ovf set on fifo_full. fifo_full beats trailer_done when both are asserted in the same cycle.
- EOT -> HOLD after exactly one cycle. eot_pulse=1 only in EOT.
- HOLD -> IDLE when hs_rx_en=0. All control outputs stay low while in HOLD.

Global rules:
- hs_rx_en=0 in any state forces IDLE on the next edge. This priority is above all other transitions.
- If hs_rx_en drops in RECEIVE there is no eot_pulse and no error.
- break_trailer_c is informational only and never changes state.
- err_sot and err_ovf stay set until err_clr=1 or reset. If err_clr and a new error event occur in the same cycle, the set wins.
- Counter arithmetic is unsigned 8-bit. cnt never wraps, because every compare value is at most 255.

## Timing
- All outputs are registered and are decoded from the next state. Every output changes on the same edge as the state transition; there is no combinational path from input to output.
- Reset values of all outputs are 0, seq_state=IDLE, cnt=0. The error flags are also cleared by reset.
- hs_rx_en rising -> SETTLE one edge later -> WAIT_SOT SETTLE_CYCLES edges after that.
- SOT pulse -> comparator_enable and rx_active high on the next edge.
- trailer_done -> rx_active low and eot_pulse high on the next edge. The following edge gives HOLD.
- Reset asserted in any state: outputs go to 0 immediately (asynchronously). The FSM resumes from IDLE on the first edge after release.

## Configuration
Macro `HS_SEQ_STATS_EN`.
- When defined:
  - Adds output `break_cnt` (8 bits), which counts break_trailer_c pulses seen in RECEIVE and saturates at 255.
  - Adds output `burst_cnt` (8 bits), which counts eot_pulse and wraps.
  - Both counters are cleared by err_clr or reset.
- When undefined: neither port nor any counter logic exists, and FSM behaviour is identical.

## Structure
- Package `hs_rx_pkg` holds:
  - the state enum (3 bits, encodings as in Operation);
  - default constants `HS_SETTLE_DEF=8` and `HS_SOT_TIMEOUT_DEF=64`.
- Sub-module `hs_seq_stats` holds the two statistics counters. It is instantiated only under HS_SEQ_STATS_EN.
- The FSM and cnt live in the top level.

## Test plan
- Nominal burst:
  - Stimulus: hs_rx_en=1 at cycle 0, sot_detected at cycle 12, trailer_done at cycle 40.
  - Required: WAIT_SOT at cycle 9; rx_active high on cycles 13..40; eot_pulse high at cycle 41; HOLD at 42; IDLE one edge after hs_rx_en=0.
- SOT timeout:
  - Stimulus: no sot_detected for 64 WAIT_SOT cycles.
  - Required: err_sot=1, state HOLD, comparator_enable stays 0.
  - Then err_clr=1 -> err_sot=0.
- Overflow tie:
  - Stimulus: fifo_full and trailer_done asserted in the same RECEIVE cycle.
  - Required: err_ovf=1, no eot_pulse, state HOLD.
- Abort:
  - Stimulus: hs_rx_en=0 mid-RECEIVE.
  - Required: IDLE next edge, all outputs 0, no error flags.
- Async reset:
  - Stimulus: RST low mid-RECEIVE, between clock edges.
  - Required: rx_active=0 and seq_state=0 immediately; restart works after release.
- Stats (HS_SEQ_STATS_EN defined):
  - Stimulus: 300 break_trailer_c pulses in RECEIVE.
  - Required: break_cnt=255.
  - Stimulus: 3 completed bursts. Required: burst_cnt=3.
